// File: rtl/prog_sequence_detector.sv
// rtl/prog_sequence_detector.sv - programmable symbol sequence detector with saturating match counter
module prog_sequence_detector #(
    parameter int DATA_W  = 3,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int AW = $clog2(MAX_LEN),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [LW-1:0]     cfg_len,
    input  logic              overlap_en,
    input  logic              count_clr,
    output logic              sequence_found,
    output logic [CNT_W-1:0]  match_count
);

    localparam logic [AW-1:0] FILL_MAX = AW'(MAX_LEN - 1);

    logic [DATA_W-1:0] pat  [MAX_LEN];
    logic [DATA_W-1:0] hist [MAX_LEN-1];
    logic [AW-1:0]     fill;
    logic [MAX_LEN:1]  cand;
    logic [MAX_LEN:1]  len_sel;
    logic              len_ok;
    logic              accept;
    logic              hit;

    // Power-on pattern inherited from the fixed-sequence detector this block replaces.
    function automatic logic [DATA_W-1:0] legacy_sym(input int idx);
        logic [2:0] v;
        case (idx)
            0:       v = 3'b001;
            1:       v = 3'b101;
            2:       v = 3'b110;
            3:       v = 3'b000;
            4:       v = 3'b110;
            5:       v = 3'b110;
            6:       v = 3'b011;
            7:       v = 3'b101;
            default: v = 3'b000;
        endcase
        return DATA_W'(v);
    endfunction

    assign accept = in_valid && !cfg_we;

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_pat
        logic [DATA_W-1:0] slot;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                slot <= legacy_sym(i);
            end else if (cfg_we && (cfg_addr == AW'(i))) begin
                slot <= cfg_data;
            end
        end

        assign pat[i] = slot;
    end

    for (genvar k = 0; k < MAX_LEN - 1; k++) begin : g_hist
        logic [DATA_W-1:0] slot;

        if (k == 0) begin : g_head
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot <= '0;
                end else if (accept) begin
                    slot <= data;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot <= '0;
                end else if (accept) begin
                    slot <= hist[k-1];
                end
            end
        end

        assign hist[k] = slot;
    end

    // One candidate comparator per possible length; cfg_len merely selects one,
    // so length changes take effect immediately without touching history.
    for (genvar l = 1; l <= MAX_LEN; l++) begin : g_len
        logic [MAX_LEN-2:0] eq;

        for (genvar j = 0; j < MAX_LEN - 1; j++) begin : g_cmp
            if (j < l - 1) begin : g_used
                assign eq[j] = (hist[j] == pat[l-2-j]);
            end else begin : g_unused
                assign eq[j] = 1'b1;
            end
        end

        assign cand[l]    = (int'(fill) >= l - 1) && (data == pat[l-1]) && (&eq);
        assign len_sel[l] = (cfg_len == LW'(l));
    end

    assign len_ok         = |len_sel;
    assign hit            = |(cand & len_sel);
    assign sequence_found = !reset && in_valid && len_ok && hit;

    // A pattern write or a non-overlapping match restarts the history window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill <= '0;
        end else if (cfg_we || (sequence_found && !overlap_en)) begin
            fill <= '0;
        end else if (accept && (fill != FILL_MAX)) begin
            fill <= fill + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
        end else if (count_clr) begin
            match_count <= '0;
        end else if (sequence_found && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_sequence_detector.sv
// tb/tb_prog_sequence_detector.sv - table-driven scoreboard bench for prog_sequence_detector
module tb_prog_sequence_detector;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [2:0] data;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [2:0] cfg_data;
    logic [3:0] cfg_len;
    logic       overlap_en;
    logic       count_clr;
    logic       sequence_found;
    logic [7:0] match_count;
    logic       found2;
    logic [1:0] count2;

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic       we;
        logic [2:0] addr;
        logic [2:0] wd;
        logic [3:0] len;
        logic       ov;
        logic       clr;
        logic       exp;
    } vec_t;

    vec_t tbl[$];
    logic exp_q[$];
    int   exp_cnt;
    int   exp_cnt2;
    int   n_checks;
    int   n_pass;
    int   step;

    prog_sequence_detector dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data(data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
        .overlap_en(overlap_en), .count_clr(count_clr),
        .sequence_found(sequence_found), .match_count(match_count)
    );

    prog_sequence_detector #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data(data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
        .overlap_en(overlap_en), .count_clr(count_clr),
        .sequence_found(found2), .match_count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, got, want);
        end
    endtask

    function automatic vec_t mk(input int v, input int d, input int we, input int addr,
                                input int wd, input int len, input int ov, input int clr,
                                input int e);
        vec_t t;
        t.v    = 1'(v);
        t.d    = 3'(d);
        t.we   = 1'(we);
        t.addr = 3'(addr);
        t.wd   = 3'(wd);
        t.len  = 4'(len);
        t.ov   = 1'(ov);
        t.clr  = 1'(clr);
        t.exp  = 1'(e);
        return t;
    endfunction

    task automatic beat(input int d, input int len, input int ov, input int e);
        tbl.push_back(mk(1, d, 0, 0, 0, len, ov, 0, e));
    endtask

    task automatic idle(input int len);
        tbl.push_back(mk(0, 5, 0, 0, 0, len, 0, 0, 0));
    endtask

    task automatic apply(input vec_t t);
        logic e;
        @(negedge clk);
        in_valid   = t.v;
        data       = t.d;
        cfg_we     = t.we;
        cfg_addr   = t.addr;
        cfg_data   = t.wd;
        cfg_len    = t.len;
        overlap_en = t.ov;
        count_clr  = t.clr;
        exp_q.push_back(t.exp);
        #1;
        e = exp_q.pop_front();
        check("sequence_found", int'(sequence_found), int'(e));
        check("sequence_found_cnt2", int'(found2), int'(e));
        if (t.clr) begin
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else if (e) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        @(posedge clk);
        #1;
        check("match_count", int'(match_count), exp_cnt);
        check("match_count_cnt2", int'(count2), exp_cnt2);
        step++;
    endtask

    task automatic run_table();
        while (tbl.size() > 0) apply(tbl.pop_front());
    endtask

    // Reset raised between edges with a beat on the bus that would match len=1 unless gated.
    task automatic async_reset();
        @(negedge clk);
        in_valid  = 1'b1;
        data      = 3'd1;
        cfg_we    = 1'b0;
        cfg_len   = 4'd1;
        count_clr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("reset_found", int'(sequence_found), 0);
        check("reset_count", int'(match_count), 0);
        check("reset_count2", int'(count2), 0);
        exp_cnt  = 0;
        exp_cnt2 = 0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset    = 1'b0;
    endtask

    int seq [8] = '{1, 5, 6, 0, 6, 6, 3, 5};

    initial begin
        n_checks = 0;
        n_pass   = 0;
        step     = 0;
        exp_cnt  = 0;
        exp_cnt2 = 0;
        reset      = 1'b1;
        in_valid   = 1'b1;
        data       = 3'd1;
        cfg_we     = 1'b0;
        cfg_addr   = 3'd0;
        cfg_data   = 3'd0;
        cfg_len    = 4'd1;
        overlap_en = 1'b0;
        count_clr  = 1'b0;
        #12;
        check("por_found", int'(sequence_found), 0);
        check("por_count", int'(match_count), 0);
        check("por_count2", int'(count2), 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;

        // Legacy pat[0]=1 with len=1
        beat(1, 1, 1, 1);
        // Full default sequence, non-overlapping
        for (int i = 0; i < 8; i++) beat(seq[i], 8, 0, (i == 7) ? 1 : 0);
        // Same sequence with 1-3 idle cycles between beats
        for (int i = 0; i < 8; i++) begin
            beat(seq[i], 8, 0, (i == 7) ? 1 : 0);
            if (i < 7) for (int g = 0; g <= (i % 3); g++) idle(8);
        end
        // Write after 7 correct beats clears history
        for (int i = 0; i < 7; i++) beat(seq[i], 8, 0, 0);
        tbl.push_back(mk(1, 2, 1, 7, 5, 8, 0, 0, 0));
        beat(5, 8, 0, 0);
        // Write cycle matches against the pre-write pattern
        for (int i = 0; i < 7; i++) beat(seq[i], 8, 0, 0);
        tbl.push_back(mk(1, 5, 1, 7, 5, 8, 0, 0, 1));
        // Invalid len 0 for the prefix, then live switch to 8 keeps history
        for (int i = 0; i < 7; i++) beat(seq[i], 0, 0, 0);
        beat(5, 8, 0, 1);
        // len = MAX_LEN+1 never matches
        for (int i = 0; i < 8; i++) beat(seq[i], 9, 0, 0);
        // Length-2 all-zero pattern
        tbl.push_back(mk(0, 0, 1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 2, 0, 0, 0));
        beat(0, 2, 0, 0); beat(0, 2, 0, 1); beat(0, 2, 0, 0); beat(0, 2, 0, 1);
        beat(0, 2, 1, 0); beat(0, 2, 1, 1); beat(0, 2, 1, 1); beat(0, 2, 1, 1);
        // len=1 against written pat[0]=0, then clear colliding with a match
        beat(0, 1, 1, 1);
        beat(3, 1, 1, 0);
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1));
        beat(0, 1, 1, 1);
        run_table();

        // Reset mid-sequence: restores legacy pattern and discards progress
        async_reset();
        for (int i = 0; i < 5; i++) beat(seq[i], 8, 0, 0);
        run_table();
        async_reset();
        beat(6, 8, 0, 0); beat(3, 8, 0, 0); beat(5, 8, 0, 0);
        for (int i = 0; i < 8; i++) beat(seq[i], 8, 0, (i == 7) ? 1 : 0);
        run_table();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_sequence_detector.md
PROG_SEQUENCE_DETECTOR -- requirements
Module: prog_sequence_detector

Interface
REQ-001 Parameter DATA_W, default 3, symbol width in bits (>=1).
REQ-002 Parameter MAX_LEN, default 8, maximum pattern length in symbols (>=2).
REQ-003 Parameter CNT_W, default 8, match counter width.
REQ-004 Derived widths: AW = clog2(MAX_LEN); LW = clog2(MAX_LEN+1).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  data carries a symbol this cycle.
REQ-009 data  in  DATA_W  input symbol.
REQ-010 cfg_we  in  1  pattern write strobe.
REQ-011 cfg_addr  in  AW  pattern slot to write; 0 = first symbol of the sequence.
REQ-012 cfg_data  in  DATA_W  pattern symbol to write.
REQ-013 cfg_len  in  LW  active pattern length.
REQ-014 overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-015 count_clr  in  1  synchronous clear of match_count.
REQ-016 sequence_found  out  1  Mealy match pulse.
REQ-017 match_count  out  CNT_W  saturating count of matches.

Function
REQ-018 Storage: the pattern store pat[0..MAX_LEN-1] of DATA_W is written when cfg_we=1 at the clock edge: pat[cfg_addr] <= cfg_data.
- Writes with cfg_addr >= MAX_LEN are ignored.
REQ-019 Storage: history hist[0..MAX_LEN-2] holds accepted symbols; hist[0] is the most recent.
REQ-020 Storage: fill is a counter from 0 to MAX_LEN-1, saturating; it gives the number of valid history entries.
REQ-021 Accepted beat: a beat is accepted when in_valid=1 and cfg_we=0.
- On an accepted beat, history shifts: hist[0] <= data.
- On an accepted beat, fill increments, saturating, except as stated in REQ-024.
REQ-022 Length range: cfg_len is valid only in 1..MAX_LEN.
- When cfg_len is outside that range, sequence_found is held at 0.
- History still updates.
REQ-023 Match condition: sequence_found is combinational (Mealy) and is 1 only when all of the following hold:
- in_valid=1;
- cfg_len L is valid;
- fill >= L-1;
- data == pat[L-1];
- hist[j] == pat[L-2-j] for all j in 0..L-2.
- The output therefore coincides with the arrival of the final symbol.
REQ-024 Non-overlap mode (overlap_en=0): on a match, fill <= 0 at the next edge and the matching symbol is not counted toward the next match.
REQ-025 Overlap mode (overlap_en=1): on a match, history and fill update as for any accepted beat.
REQ-026 Idle cycle: when in_valid=0, history and fill hold and sequence_found=0.
REQ-027 cfg_we cycle: a cycle with cfg_we=1 evaluates the match against the pre-write pattern.
- At the next edge, fill <= 0 and data is not shifted into history.
REQ-028 Live controls: cfg_len and overlap_en are used live each cycle; changing either does not clear history.
REQ-029 Counter: match_count increments by 1 at each edge where sequence_found=1 and saturates at 2^CNT_W-1.
REQ-030 Counter: count_clr=1 forces match_count to 0 at the next edge; it takes priority over a simultaneous match.

Reset
REQ-031 While reset=1, immediately: fill=0, hist all 0, match_count=0.
- sequence_found is 0 while reset=1, regardless of other inputs.
REQ-032 Reset pattern values: pat[i] takes the legacy sequence 001,101,110,000,110,110,011,101 for i<8, each value truncated or zero-extended to DATA_W; slots i>=8 reset to 0.
REQ-033 Reset mid-sequence discards all partial-match progress; detection restarts from an empty history after deassertion.

Verification
REQ-034 Default parameters, reset, cfg_len=8, overlap_en=0, then 8 consecutive valid beats 1,5,6,0,6,6,3,5 -> sequence_found=1 only on the 8th beat; match_count=1.
REQ-035 Pattern length 2 with pat[0]=pat[1]=0 (written via cfg_we), then valid symbols 0,0,0,0:
- overlap_en=0 -> pulses on beats 2 and 4, match_count=2;
- overlap_en=1 -> pulses on beats 2, 3 and 4, match_count=3.
REQ-036 Default sequence with in_valid=0 gaps of 1-3 cycles inserted between beats -> a single pulse on the final valid beat; sequence_found=0 in every idle cycle.
REQ-037 Reset asserted asynchronously between clock edges after 5 correct beats, then released, then beats 6,3,5 -> no pulse; a full 8-beat sequence afterwards -> one pulse.
REQ-038 cfg_we write after 7 correct beats, then beat 5 -> no pulse (history cleared).
- With cfg_len=0 or cfg_len=MAX_LEN+1 -> no pulse for any stimulus.
REQ-039 CNT_W=2, four matches -> match_count=3 (saturated); count_clr asserted in the same cycle as a match -> match_count=0.
